// File: rtl/wb_queue.sv
// wb_queue: write-back queue that merges load-unit and ALU results into a
// single register-file write port, using a circular FIFO of {rd, data} entries.
// Loads have fixed priority over the ALU; one enqueue per cycle; the head
// retires on every edge where the queue is non-empty.
// Optional build macro WB_QUEUE_FWD_EN: when defined, adds combinational
// forwarding of the youngest pending write for two decode source indices;
// when undefined, the forwarding outputs are tied to zero.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [4:0]                 ld_rd,
  input  logic [XLEN-1:0]            ld_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  output logic                       RegWrite,
  output logic [4:0]                 WriteRegister,
  output logic [XLEN-1:0]            WriteData,
  input  logic [4:0]                 rs1_idx,
  input  logic [4:0]                 rs2_idx,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [XLEN-1:0]            fwd1_data,
  output logic [XLEN-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_ld_fire;
  logic            w_alu_fire;
  logic            w_enq;
  logic            w_deq;
  logic [4:0]      w_enq_rd;
  logic [XLEN-1:0] w_enq_data;

  assign w_full     = (r_count == CW'(DEPTH));
  assign ld_ready   = !w_full;
  assign alu_ready  = !w_full && !ld_valid;
  assign w_ld_fire  = ld_valid && ld_ready;
  assign w_alu_fire = alu_valid && alu_ready;
  assign w_deq      = (r_count != '0);
  assign count      = r_count;

  // Select the source being enqueued; x0 destinations complete the handshake but are dropped.
  always_comb begin
    w_enq      = 1'b0;
    w_enq_rd   = '0;
    w_enq_data = '0;
    if (w_ld_fire) begin
      w_enq      = (ld_rd != 5'd0);
      w_enq_rd   = ld_rd;
      w_enq_data = ld_data;
    end else if (w_alu_fire) begin
      w_enq      = (alu_rd != 5'd0);
      w_enq_rd   = alu_rd;
      w_enq_data = alu_data;
    end
  end

  // Pointer and occupancy update; reset overrides any handshake or retirement.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + 1'b1;
      if (w_deq) r_head <= r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care while unoccupied so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_rd[r_tail]   <= w_enq_rd;
      r_data[r_tail] <= w_enq_data;
    end
  end

  // Register-file write port driven from the head entry, zeroed when empty.
  always_comb begin
    RegWrite      = w_deq;
    WriteRegister = '0;
    WriteData     = '0;
    if (w_deq) begin
      WriteRegister = r_rd[r_head];
      WriteData     = r_data[r_head];
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Scan occupied entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    logic [AW-1:0] v_idx;
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    v_idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      v_idx = r_head + AW'(i);
      if (CW'(i) < r_count) begin
        if (rs1_idx != 5'd0 && r_rd[v_idx] == rs1_idx) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_data[v_idx];
        end
        if (rs2_idx != 5'd0 && r_rd[v_idx] == rs2_idx) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_data[v_idx];
        end
      end
    end
  end
`else
  logic w_unused_idx;
  assign w_unused_idx = ^{rs1_idx, rs2_idx};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule
